// File: rtl/calcn_pkg.sv
// Shared types, widths and the single-cycle ALU for the calcn N-port datapath.
// Request storage uses these package widths; the core's DATA_W/TAG_W must match them.
package calcn_pkg;

    localparam int unsigned CALCN_DATA_W = 32;
    localparam int unsigned CALCN_TAG_W  = 2;
    localparam int unsigned CALCN_CMD_W  = 4;
    localparam int unsigned SHAMT_W      = $clog2(CALCN_DATA_W);

    typedef enum logic [CALCN_CMD_W-1:0] {
        CmdNop = 4'd0,
        CmdAdd = 4'd1,
        CmdSub = 4'd2,
        CmdShl = 4'd5,
        CmdShr = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RespNone = 2'd0,
        RespOk   = 2'd1,
        RespOvf  = 2'd2,
        RespInv  = 2'd3
    } resp_e;

    // cmd is kept as a raw vector so undefined opcodes survive the queue intact
    typedef struct packed {
        logic [CALCN_CMD_W-1:0]  cmd;
        logic [CALCN_TAG_W-1:0]  tag;
        logic [CALCN_DATA_W-1:0] op1;
        logic [CALCN_DATA_W-1:0] op2;
    } calcn_req_t;

    typedef struct packed {
        resp_e                   resp;
        logic [CALCN_DATA_W-1:0] data;
    } alu_res_t;

    function automatic alu_res_t calcn_alu(input logic [CALCN_CMD_W-1:0]  cmd,
                                           input logic [CALCN_DATA_W-1:0] op1,
                                           input logic [CALCN_DATA_W-1:0] op2);
        alu_res_t                res;
        logic [CALCN_DATA_W:0]   sum;
        logic [SHAMT_W-1:0]      shamt;
        res.resp = RespInv;
        res.data = '0;
        sum      = {1'b0, op1} + {1'b0, op2};
        shamt    = op2[SHAMT_W-1:0];
        case (cmd)
            CmdNop: res.resp = RespNone;
            CmdAdd: begin
                if (sum[CALCN_DATA_W]) begin
                    res.resp = RespOvf;
                end else begin
                    res.resp = RespOk;
                    res.data = sum[CALCN_DATA_W-1:0];
                end
            end
            CmdSub: begin
                if (op1 < op2) begin
                    res.resp = RespOvf;
                end else begin
                    res.resp = RespOk;
                    res.data = op1 - op2;
                end
            end
            CmdShl: begin
                res.resp = RespOk;
                res.data = op1 << shamt;
            end
            CmdShr: begin
                res.resp = RespOk;
                res.data = op1 >> shamt;
            end
            default: begin
                res.resp = RespInv;
                res.data = '0;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/calcn_port_queue.sv
// One request port: two-cycle capture FSM feeding a FIFO, with a registered full flag.
module calcn_port_queue
    import calcn_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    c_clk,
    input  logic                    reset,
    input  logic [CALCN_CMD_W-1:0]  cmd_i,
    input  logic [CALCN_DATA_W-1:0] data_i,
    input  logic [CALCN_TAG_W-1:0]  tag_i,
    input  logic                    pop_i,
    output logic                    busy_o,
    output logic                    empty_o,
    output calcn_req_t              head_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0] Full = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {StIdle, StOp2} cap_state_e;

    cap_state_e              state_q;
    logic [CALCN_CMD_W-1:0]  cmd_q;
    logic [CALCN_TAG_W-1:0]  tag_q;
    logic [CALCN_DATA_W-1:0] op1_q;
    calcn_req_t              mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]         wptr_q;
    logic [PtrW-1:0]         rptr_q;
    logic [PtrW:0]           count_q;
    logic [PtrW:0]           count_d;
    logic                    busy_q;
    logic                    push;

    // The IDLE check reserved a slot one cycle ago; only pops happened since.
    assign push = (state_q == StOp2);

    always_comb begin
        count_d = count_q;
        if (push && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cmd_q   <= '0;
            tag_q   <= '0;
            op1_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if ((cmd_i != '0) && !busy_q) begin
                        cmd_q   <= cmd_i;
                        tag_q   <= tag_i;
                        op1_q   <= data_i;
                        state_q <= StOp2;
                    end
                end
                StOp2: begin
                    mem_q[wptr_q] <= '{cmd: cmd_q, tag: tag_q, op1: op1_q, op2: data_i};
                    wptr_q        <= wptr_q + 1'b1;
                    state_q       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
            if (pop_i) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_d;
            busy_q  <= (count_d == Full);
        end
    end

    assign busy_o  = busy_q;
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/calcn_core.sv
// N-port calculator: per-port request queues, round-robin issue to one shared ALU,
// and a registered response demux back to the originating port.
module calcn_core
    import calcn_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_W     = CALCN_DATA_W,
    parameter int unsigned TAG_W      = CALCN_TAG_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                               c_clk,
    input  logic                               reset,
    input  logic [NUM_PORTS-1:0][3:0]          req_cmd_in,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]   req_data_in,
    input  logic [NUM_PORTS-1:0][TAG_W-1:0]    req_tag_in,
    output logic [NUM_PORTS-1:0]               req_busy,
    output logic [NUM_PORTS-1:0][1:0]          out_resp,
    output logic [NUM_PORTS-1:0][DATA_W-1:0]   out_data,
    output logic [NUM_PORTS-1:0][TAG_W-1:0]    out_tag
);

    localparam int unsigned PortW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] pop;
    calcn_req_t           heads [NUM_PORTS];

    // ptr_q is the first port searched next cycle, i.e. last grant + 1.
    logic [PortW-1:0] ptr_q;
    logic [PortW-1:0] ptr_d;
    logic [PortW-1:0] gnt_idx;
    logic             gnt_valid;
    calcn_req_t       gnt_req;
    alu_res_t         alu_res;

    always_comb begin
        logic [PortW-1:0] cand;
        cand      = '0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = PortW'((32'(ptr_q) + i) % NUM_PORTS);
            if (!gnt_valid && !empty[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_valid) begin
            ptr_d = PortW'((32'(gnt_idx) + 1) % NUM_PORTS);
        end
    end

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt_req = heads[gnt_idx];
    assign alu_res = calcn_alu(gnt_req.cmd, gnt_req.op1, gnt_req.op2);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [1:0]        resp_q;
        logic [DATA_W-1:0] data_q;
        logic [TAG_W-1:0]  tag_q;

        calcn_port_queue #(
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_queue (
            .c_clk   (c_clk),
            .reset   (reset),
            .cmd_i   (req_cmd_in[p]),
            .data_i  (req_data_in[p]),
            .tag_i   (req_tag_in[p]),
            .pop_i   (pop[p]),
            .busy_o  (req_busy[p]),
            .empty_o (empty[p]),
            .head_o  (heads[p])
        );

        assign pop[p] = gnt_valid && (gnt_idx == PortW'(p));

        // Responses are one-cycle pulses; idle ports drive all zeros.
        always_ff @(posedge c_clk) begin
            if (!reset) begin
                resp_q <= '0;
                data_q <= '0;
                tag_q  <= '0;
            end else if (pop[p]) begin
                resp_q <= alu_res.resp;
                data_q <= alu_res.data;
                tag_q  <= gnt_req.tag;
            end else begin
                resp_q <= '0;
                data_q <= '0;
                tag_q  <= '0;
            end
        end

        assign out_resp[p] = resp_q;
        assign out_data[p] = data_q;
        assign out_tag[p]  = tag_q;
    end

endmodule

// File: tb/tb_calcn_core.sv
// Scoreboard bench for calcn_core: expectations queued at issue, matched per port on response.
module tb_calcn_core;

    localparam int NP = 4;

    logic                  c_clk = 1'b0;
    logic                  reset;
    logic [NP-1:0][3:0]    req_cmd_in;
    logic [NP-1:0][31:0]   req_data_in;
    logic [NP-1:0][1:0]    req_tag_in;
    logic [NP-1:0]         req_busy;
    logic [NP-1:0][1:0]    out_resp;
    logic [NP-1:0][31:0]   out_data;
    logic [NP-1:0][1:0]    out_tag;

    calcn_core #(
        .NUM_PORTS  (NP),
        .DATA_W     (32),
        .TAG_W      (2),
        .FIFO_DEPTH (4)
    ) u_dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .req_tag_in  (req_tag_in),
        .req_busy    (req_busy),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .out_tag     (out_tag)
    );

    always #5 c_clk = ~c_clk;

    typedef struct {
        int         port;
        logic [1:0] resp;
        logic [31:0] data;
        logic [1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   seen_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   cmd_cyc = 0;
    int   resp_cyc[NP];
    bit   saw_busy0;
    int   drops0;

    logic [3:0]  r_cmd[NP];
    logic [1:0]  r_tag[NP];
    logic [31:0] r_a[NP];
    logic [31:0] r_b[NP];
    logic [1:0]  r_resp[NP];
    logic [31:0] r_data[NP];

    always @(posedge c_clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference ALU: returns {resp, data}
    function automatic logic [33:0] model(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (cmd)
            4'd0:    return {2'd0, 32'd0};
            4'd1:    return s[32] ? {2'd2, 32'd0} : {2'd1, s[31:0]};
            4'd2:    return (a < b) ? {2'd2, 32'd0} : {2'd1, a - b};
            4'd5:    return {2'd1, a << b[4:0]};
            4'd6:    return {2'd1, a >> b[4:0]};
            default: return {2'd3, 32'd0};
        endcase
    endfunction

    // Response monitor: match the oldest expectation for that port
    always @(negedge c_clk) begin
        for (int p = 0; p < NP; p++) begin
            if (out_resp[p] != 2'd0) begin
                int idx;
                idx = -1;
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (idx < 0 && exp_q[i].port == p) idx = i;
                end
                if (idx < 0) begin
                    check_val($sformatf("unexpected_resp_p%0d", p), 64'(out_resp[p]), 64'd0);
                end else begin
                    check_val($sformatf("resp_p%0d", p), 64'(out_resp[p]), 64'(exp_q[idx].resp));
                    check_val($sformatf("data_p%0d", p), 64'(out_data[p]), 64'(exp_q[idx].data));
                    check_val($sformatf("tag_p%0d", p), 64'(out_tag[p]), 64'(exp_q[idx].tag));
                    exp_q.delete(idx);
                    seen_q.push_back(p);
                    resp_cyc[p] = cyc;
                end
            end else if (out_data[p] != 32'd0 || out_tag[p] != 2'd0) begin
                check_val($sformatf("idle_zero_p%0d", p), {30'd0, out_tag[p], out_data[p]}, 64'd0);
            end
        end
    end

    task automatic set_req(input int p, input logic [3:0] cmd, input logic [1:0] tag,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] resp, input logic [31:0] data);
        r_cmd[p]  = cmd;
        r_tag[p]  = tag;
        r_a[p]    = a;
        r_b[p]    = b;
        r_resp[p] = resp;
        r_data[p] = data;
    endtask

    task automatic set_rand(input int p);
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [33:0] m;
        case ($urandom_range(6))
            0:       cmd = 4'd0;
            1:       cmd = 4'd1;
            2:       cmd = 4'd2;
            3:       cmd = 4'd5;
            4:       cmd = 4'd6;
            5:       cmd = 4'd9;
            default: cmd = 4'd3;
        endcase
        a = $urandom;
        b = ($urandom_range(1) == 1) ? $urandom : 32'($urandom_range(40));
        m = model(cmd, a, b);
        set_req(p, cmd, 2'($urandom_range(3)), a, b, m[33:32], m[31:0]);
    endtask

    // Two-cycle slot: command+op1, then op2. Commands seen while busy expect no response.
    task automatic issue_round();
        logic [NP-1:0] acc;
        exp_t          e;
        for (int p = 0; p < NP; p++) begin
            acc[p] = (r_cmd[p] != 4'd0) && !req_busy[p];
            if (p == 0 && r_cmd[0] != 4'd0 && req_busy[0]) begin
                saw_busy0 = 1'b1;
                drops0++;
            end
            req_cmd_in[p]  = r_cmd[p];
            req_tag_in[p]  = r_tag[p];
            req_data_in[p] = r_a[p];
        end
        @(negedge c_clk);
        cmd_cyc = cyc;
        for (int p = 0; p < NP; p++) begin
            req_cmd_in[p]  = 4'd0;
            req_data_in[p] = r_b[p];
            if (acc[p]) begin
                e.port = p;
                e.resp = r_resp[p];
                e.data = r_data[p];
                e.tag  = r_tag[p];
                exp_q.push_back(e);
            end
        end
        @(negedge c_clk);
        for (int p = 0; p < NP; p++) r_cmd[p] = 4'd0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge c_clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check_val("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        repeat (2) @(negedge c_clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge c_clk);
        reset = 1'b1;
        @(negedge c_clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        req_cmd_in  = '0;
        req_data_in = '0;
        req_tag_in  = '0;
        saw_busy0   = 1'b0;
        drops0      = 0;
        for (int p = 0; p < NP; p++) begin
            resp_cyc[p] = -1;
            set_req(p, 4'd0, 2'd0, 32'd0, 32'd0, 2'd0, 32'd0);
        end
        repeat (3) @(negedge c_clk);
        check_val("rst_resp", 64'(out_resp), 64'd0);
        check_val("rst_data", 64'(out_data[0] | out_data[1] | out_data[2] | out_data[3]), 64'd0);
        check_val("rst_tag", 64'(out_tag), 64'd0);
        check_val("rst_busy", 64'(req_busy), 64'd0);
        reset = 1'b1;
        @(negedge c_clk);

        // Single add on port 1 with latency check
        set_req(1, 4'd1, 2'd2, 32'h10, 32'h20, 2'd1, 32'h30);
        issue_round();
        wait_drain(50);
        check_val("lat_p1", 64'(resp_cyc[1]), 64'(cmd_cyc + 2));

        // Boundary vectors
        set_req(0, 4'd1, 2'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'h0);
        set_req(1, 4'd5, 2'd1, 32'h1, 32'h24, 2'd1, 32'h10);
        set_req(2, 4'd2, 2'd3, 32'h5, 32'h7, 2'd2, 32'h0);
        set_req(3, 4'd9, 2'd0, 32'h1234, 32'h1, 2'd3, 32'h0);
        issue_round();
        set_req(0, 4'd2, 2'd2, 32'h7, 32'h5, 2'd1, 32'h2);
        set_req(1, 4'd6, 2'd3, 32'h8000_0000, 32'h21, 2'd1, 32'h4000_0000);
        set_req(2, 4'd1, 2'd0, 32'h7FFF_FFFF, 32'h1, 2'd1, 32'h8000_0000);
        set_req(3, 4'd15, 2'd1, 32'h1, 32'h1, 2'd3, 32'h0);
        issue_round();
        wait_drain(50);

        // Round-robin order from a fresh pointer, then again after wrap
        do_reset();
        for (int rnd = 0; rnd < 2; rnd++) begin
            seen_q.delete();
            for (int p = 0; p < NP; p++) begin
                set_req(p, 4'd1, 2'(p), 32'(p + 16 * rnd), 32'd1, 2'd1, 32'(p + 16 * rnd + 1));
            end
            issue_round();
            wait_drain(50);
            check_val($sformatf("rr_count_%0d", rnd), 64'(seen_q.size()), 64'd4);
            for (int i = 0; i < NP; i++) begin
                check_val($sformatf("rr_order_%0d_%0d", rnd, i), 64'(seen_q[i]), 64'(i));
            end
        end

        // Port 0 back-to-back with no contention: never busy
        for (int i = 0; i < 5; i++) begin
            set_req(0, 4'd1, 2'(i), 32'(i), 32'h100, 2'd1, 32'(32'h100 + i));
            issue_round();
            check_val($sformatf("b2b_busy0_%0d", i), 64'(req_busy[0]), 64'd0);
        end
        wait_drain(50);

        // All ports saturated: port 0 must fill, assert busy and drop commands
        do_reset();
        saw_busy0 = 1'b0;
        drops0    = 0;
        for (int r = 0; r < 12; r++) begin
            for (int p = 0; p < NP; p++) begin
                set_req(p, 4'd1, 2'(r % 4), 32'(32'h1000 * p + r), 32'd1, 2'd1,
                        32'(32'h1000 * p + r + 1));
            end
            issue_round();
        end
        wait_drain(200);
        check_val("sat_busy0_seen", 64'(saw_busy0), 64'd1);
        check_val("sat_drop0", 64'(drops0 > 0), 64'd1);
        check_val("sat_busy_clear", 64'(req_busy), 64'd0);

        // Reset between command and operand2 discards the request
        req_cmd_in[2]  = 4'd1;
        req_tag_in[2]  = 2'd1;
        req_data_in[2] = 32'h5;
        @(negedge c_clk);
        req_cmd_in[2]  = 4'd0;
        req_data_in[2] = 32'h6;
        reset          = 1'b0;
        @(negedge c_clk);
        check_val("midrst_resp", 64'(out_resp), 64'd0);
        check_val("midrst_tag", 64'(out_tag), 64'd0);
        check_val("midrst_busy", 64'(req_busy), 64'd0);
        reset = 1'b1;
        repeat (6) @(negedge c_clk);
        set_req(2, 4'd1, 2'd3, 32'h100, 32'h23, 2'd1, 32'h123);
        issue_round();
        wait_drain(50);

        // Random mix including no-ops and invalid opcodes
        for (int r = 0; r < 8; r++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(3) != 0) set_rand(p);
            end
            issue_round();
        end
        wait_drain(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
